// File: rtl/prim_clock_sel_ctrl.sv
// Clock-switch sequencer that drives the select of the downstream 2:1 clock mux.
// Define PRIM_CLOCK_SEL_CTRL_LOCK_SYNC_EN to pass lock_i through a 2-flop synchronizer.
module prim_clock_sel_ctrl #(
  parameter int unsigned GateCycles   = 4,
  parameter int unsigned SettleCycles = 8,
  parameter int unsigned LockTimeout  = 1024,
  parameter logic        ResetSel     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid_i,
  input  logic req_sel_i,
  output logic req_ready_o,
  input  logic lock_i,
  output logic sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam int unsigned MaxGS    = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
  localparam int unsigned MaxCount = (LockTimeout > MaxGS) ? LockTimeout : MaxGS;
  localparam int unsigned CntW     = $clog2(MaxCount + 1);

  localparam logic [CntW-1:0] LockLast   = CntW'(LockTimeout - 1);
  localparam logic [CntW-1:0] GateLast   = CntW'(GateCycles - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    GATE      = 3'd2,
    SWITCH    = 3'd3,
    SETTLE    = 3'd4
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            tgt_q;
  logic            sel_q;
  logic            clk_en_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic            lock_s;

`ifdef PRIM_CLOCK_SEL_CTRL_LOCK_SYNC_EN
  logic lock_meta_q;
  logic lock_sync_q;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= lock_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign lock_s = lock_sync_q;
`else
  assign lock_s = lock_i;
`endif

  // Sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgt_q    <= ResetSel;
      sel_q    <= ResetSel;
      clk_en_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i && ready_q) begin
            tgt_q <= req_sel_i;
            if (req_sel_i == sel_q) begin
              done_q <= 1'b1;
            end else begin
              state_q <= WAIT_LOCK;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT_LOCK: begin
          // Lock is checked first so it wins over a coincident timeout.
          if (lock_s) begin
            state_q  <= GATE;
            cnt_q    <= '0;
            clk_en_q <= 1'b0;
          end else if (cnt_q == LockLast) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        GATE: begin
          if (cnt_q == GateLast) begin
            state_q <= SWITCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        SWITCH: begin
          sel_q   <= tgt_q;
          state_q <= SETTLE;
          cnt_q   <= '0;
        end
        SETTLE: begin
          if (cnt_q == SettleLast) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            clk_en_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          clk_en_q <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign sel_o       = sel_q;
  assign clk_en_o    = clk_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_prim_clock_sel_ctrl.sv
// Randomized self-checking bench for prim_clock_sel_ctrl against a transaction-level model
// derived from the lock history observed at each clock edge.
module tb_prim_clock_sel_ctrl;

  localparam int unsigned G   = 4;
  localparam int unsigned S   = 8;
  localparam int unsigned LTO = 16;
`ifdef PRIM_CLOCK_SEL_CTRL_LOCK_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Edges spent in WAIT_LOCK when lock_i rises together with the request.
  localparam int LOCK_LAT = (SYNC == 0) ? 1 : SYNC;
  localparam int N = LTO + SYNC + G + S + 4;

  typedef struct packed {
    logic done;
    logic err;
    logic clk_en;
    logic sel;
    logic busy;
    logic ready;
  } obs_t;

  localparam obs_t IDLE_OBS = '{done: 1'b0, err: 1'b0, clk_en: 1'b1, sel: 1'b0, busy: 1'b0, ready: 1'b1};

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0;
  logic req_sel_i = 1'b0;
  logic lock_i = 1'b0;
  logic req_ready_o, sel_o, clk_en_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  prim_clock_sel_ctrl #(
    .GateCycles  (G),
    .SettleCycles(S),
    .LockTimeout (LTO),
    .ResetSel    (1'b0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_sel_i  (req_sel_i),
    .req_ready_o(req_ready_o),
    .lock_i     (lock_i),
    .sel_o      (sel_o),
    .clk_en_o   (clk_en_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  int   cyc = 0;
  bit   lock_h[int];
  bit   rst_h[int];
  obs_t act_h[int];
  int   total = 0;
  int   bad = 0;
  bit   m_sel = 1'b0;

  // Edge history: inputs seen at each posedge, outputs seen after it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    lock_h[cyc] = lock_i;
    rst_h[cyc] = rst_i;
  end

  always @(negedge clk) begin
    act_h[cyc] = {done_o, err_o, clk_en_o, sel_o, busy_o, req_ready_o};
  end

  // Lock level the sequencer acts on at edge k.
  function automatic bit lock_s_at(int k);
    if (SYNC == 0) return lock_h.exists(k) ? lock_h[k] : 1'b0;
    if (!lock_h.exists(k - 2)) return 1'b0;
    if (rst_h[k - 1] || rst_h[k - 2]) return 1'b0;
    return lock_h[k - 2];
  endfunction

  // Edges in WAIT_LOCK before lock is seen (0 means the timeout fires).
  function automatic int lock_wait(int a);
    for (int k = 1; k <= int'(LTO); k++) if (lock_s_at(a + k)) return k;
    return 0;
  endfunction

  function automatic int end_edge(int a, bit t, bit m);
    int w;
    if (t == m) return a;
    w = lock_wait(a);
    return (w == 0) ? a + int'(LTO) : a + w + int'(G) + 1 + int'(S);
  endfunction

  function automatic bit sel_after(int a, bit t, bit m);
    if (t == m) return m;
    return (lock_wait(a) == 0) ? m : t;
  endfunction

  // Expected outputs after edge e for a request (target t, prior select m) accepted at edge a.
  function automatic obs_t model_at(int e, int a, bit t, bit m);
    obs_t r;
    int w, d;
    r = '{done: 1'b0, err: 1'b0, clk_en: 1'b1, sel: m, busy: 1'b0, ready: 1'b1};
    if (t == m) begin
      r.done = (e == a);
      return r;
    end
    w = lock_wait(a);
    d = end_edge(a, t, m);
    r.busy  = (e >= a) && (e < d);
    r.ready = !r.busy;
    if (w == 0) begin
      r.err = (e == d);
      return r;
    end
    r.done   = (e == d);
    r.clk_en = !((e >= a + w) && (e < d));
    r.sel    = (e >= a + w + int'(G) + 1) ? t : m;
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) begin
      req_valid_i = 1'($urandom);
      req_sel_i   = 1'($urandom);
      lock_i      = 1'($urandom);
      step();
      total++;
      if (act_h[cyc] !== IDLE_OBS)
        $display("FAIL reset cyc=%0d got=%b want=%b", cyc, act_h[cyc], IDLE_OBS);
      if (act_h[cyc] !== IDLE_OBS) bad++;
    end
    rst_i = 1'b0; req_valid_i = 1'b0; lock_i = 1'b0;
    m_sel = 1'b0;
    repeat (3) step();
    total++;
    if (act_h[cyc] !== IDLE_OBS) begin
      bad++;
      $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, act_h[cyc], IDLE_OBS);
    end
  endtask

  task automatic test_switch();
    int a, low, flips, dlat;
    bit t;
    obs_t ex;
    lock_i = 1'b0;
    repeat (3) step();
    t = !m_sel;
    req_valid_i = 1'b1; req_sel_i = t; lock_i = 1'b1;
    step();
    a = cyc;
    req_valid_i = 1'b0;
    repeat (N) step();
    low = 0; flips = 0; dlat = -1;
    for (int e = a; e <= a + N; e++) begin
      ex = model_at(e, a, t, m_sel);
      total++;
      if (act_h[e] !== ex) begin
        bad++;
        $display("FAIL switch cyc=%0d got=%b want=%b", e - a, act_h[e], ex);
      end
      if (act_h[e].clk_en === 1'b0) low++;
      if (act_h[e].sel !== act_h[e - 1].sel) flips++;
      if (act_h[e].done === 1'b1 && dlat < 0) dlat = e - a;
    end
    total++;
    if (low != int'(G + 1 + S)) begin
      bad++;
      $display("FAIL switch_gate_len got=%0d want=%0d", low, G + 1 + S);
    end
    total++;
    if (flips != 1) begin
      bad++;
      $display("FAIL switch_sel_flips got=%0d want=1", flips);
    end
    total++;
    if (dlat != LOCK_LAT + int'(G) + 1 + int'(S)) begin
      bad++;
      $display("FAIL switch_latency got=%0d want=%0d", dlat, LOCK_LAT + int'(G) + 1 + int'(S));
    end
    m_sel = sel_after(a, t, m_sel);
  endtask

  task automatic test_noop();
    int a;
    obs_t ex;
    for (int i = 0; i < 3; i++) begin
      lock_i = 1'($urandom);
      req_valid_i = 1'b1; req_sel_i = m_sel;
      step();
      a = cyc;
      req_valid_i = 1'b0;
      repeat (4) step();
      for (int e = a; e <= a + 4; e++) begin
        ex = model_at(e, a, m_sel, m_sel);
        total++;
        if (act_h[e] !== ex) begin
          bad++;
          $display("FAIL noop cyc=%0d got=%b want=%b", e - a, act_h[e], ex);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int a, errs;
    bit t;
    obs_t ex;
    lock_i = 1'b0;
    repeat (3) step();
    t = !m_sel;
    req_valid_i = 1'b1; req_sel_i = t;
    step();
    a = cyc;
    req_valid_i = 1'b0;
    repeat (LTO + 4) step();
    errs = 0;
    for (int e = a; e <= a + int'(LTO) + 4; e++) begin
      ex = model_at(e, a, t, m_sel);
      total++;
      if (act_h[e] !== ex) begin
        bad++;
        $display("FAIL timeout cyc=%0d got=%b want=%b", e - a, act_h[e], ex);
      end
      if (act_h[e].err === 1'b1) errs++;
    end
    total++;
    if (errs != 1) begin
      bad++;
      $display("FAIL timeout_err_pulses got=%0d want=1", errs);
    end
    m_sel = sel_after(a, t, m_sel);
  endtask

  task automatic test_random();
    int a, p;
    bit t;
    obs_t ex;
    int probs[5] = '{0, 3, 20, 60, 100};
    for (int it = 0; it < 25; it++) begin
      p = probs[$urandom_range(0, 4)];
      t = 1'($urandom);
      lock_i = ($urandom_range(0, 99) < p);
      req_valid_i = 1'b1; req_sel_i = t;
      step();
      a = cyc;
      req_valid_i = 1'b0;
      req_sel_i = 1'($urandom);
      for (int j = 0; j < N; j++) begin
        lock_i = ($urandom_range(0, 99) < p);
        step();
      end
      for (int e = a; e <= a + N; e++) begin
        ex = model_at(e, a, t, m_sel);
        total++;
        if (act_h[e] !== ex) begin
          bad++;
          $display("FAIL random it=%0d p=%0d cyc=%0d got=%b want=%b", it, p, e - a, act_h[e], ex);
        end
      end
      m_sel = sel_after(a, t, m_sel);
    end
  endtask

  task automatic test_reset_mid_settle();
    int a, rr;
    obs_t ex;
    lock_i = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    m_sel = 1'b0;
    repeat (4) step();
    req_valid_i = 1'b1; req_sel_i = 1'b1;
    step();
    a = cyc;
    req_valid_i = 1'b0;
    while (cyc < a + 1 + int'(G) + 1 + 3) step();
    rst_i = 1'b1;
    step();
    rr = cyc;
    rst_i = 1'b0;
    repeat (S + 4) step();
    for (int e = a; e < rr; e++) begin
      ex = model_at(e, a, 1'b1, 1'b0);
      total++;
      if (act_h[e] !== ex) begin
        bad++;
        $display("FAIL settle_pre cyc=%0d got=%b want=%b", e - a, act_h[e], ex);
      end
    end
    total++;
    if (act_h[rr - 1].sel !== 1'b1) begin
      bad++;
      $display("FAIL settle_sel_before_rst got=%b want=1", act_h[rr - 1].sel);
    end
    for (int e = rr; e <= rr + int'(S) + 4; e++) begin
      total++;
      if (act_h[e] !== IDLE_OBS) begin
        bad++;
        $display("FAIL settle_rst cyc=%0d got=%b want=%b", e - rr, act_h[e], IDLE_OBS);
      end
    end
    m_sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    int a, a2, d, guard;
    bit t, m, seen;
    obs_t ex;
    lock_i = 1'b1;
    repeat (3) step();
    m = m_sel;
    t = !m;
    req_valid_i = 1'b1; req_sel_i = t;
    step();
    a = cyc;
    step();
    req_sel_i = m;
    seen = 1'b0;
    guard = 0;
    while (!seen && guard < 60) begin
      step();
      guard++;
      if (done_o === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_first_done got=none want=pulse within 60 cycles");
      req_valid_i = 1'b0;
    end else begin
      step();
      a2 = cyc;
      req_valid_i = 1'b0;
      repeat (N) step();
      d = end_edge(a, t, m);
      for (int e = a; e <= a2 + N; e++) begin
        ex = (e <= d) ? model_at(e, a, t, m) : model_at(e, d + 1, m, t);
        total++;
        if (act_h[e] !== ex) begin
          bad++;
          $display("FAIL b2b cyc=%0d got=%b want=%b", e - a, act_h[e], ex);
        end
      end
      m_sel = sel_after(d + 1, m, sel_after(a, t, m));
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_noop();
    test_timeout();
    test_random();
    test_reset_mid_settle();
    test_back_to_back();
    test_noop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
